// File: rtl/projection_bbox_finder_pkg.sv
// rtl/projection_bbox_finder_pkg.sv - shared FSM encoding and sizing defaults for the projection bbox finder
package projection_bbox_finder_pkg;

   localparam int NUM_BINS_DEFAULT = 256;
   localparam int COUNT_W_DEFAULT  = 8;
   localparam int SUM_W_DEFAULT    = 24;
   localparam int IDX_W_DEFAULT    = $clog2(NUM_BINS_DEFAULT);

   // Load-to-quotient latency of the restoring divider: one cycle per dividend bit plus the load.
   localparam int DIV_LATENCY = IDX_W_DEFAULT + COUNT_W_DEFAULT + IDX_W_DEFAULT + 1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      COLLECT,
      DIV_X,
      DIV_Y,
      FINISH
   } bboxState_t;

   function automatic int divLatency(input int dividendW);
      return dividendW + 1;
   endfunction

endpackage

// File: rtl/projection_bbox_finder_if.sv
// rtl/projection_bbox_finder_if.sv - histogram-stage to bbox-finder link (read request plus x/y bin streams)
interface projection_bbox_finder_if #(
   parameter int COUNT_W = 8
);
   logic               readHistogram;
   logic [COUNT_W-1:0] xHistIn;
   logic               xValid;
   logic [COUNT_W-1:0] yHistIn;
   logic               yValid;

   modport master (
      input  readHistogram,
      output xHistIn,
      output xValid,
      output yHistIn,
      output yValid
   );

   modport slave (
      output readHistogram,
      input  xHistIn,
      input  xValid,
      input  yHistIn,
      input  yValid
   );
endinterface

// File: rtl/projection_bbox_finder_seq_divider.sv
// rtl/projection_bbox_finder_seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
// Instantiated by projection_bbox_finder only when CENTROID_EN is defined.
module projection_bbox_finder_seq_divider #(
   parameter int DIVIDEND_W = 24,
   parameter int DIVISOR_W  = 16,
   parameter int QUOTIENT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [QUOTIENT_W-1:0] quotient,
   output logic                  quotientValid
);
   localparam int CNT_W = $clog2(DIVIDEND_W + 1);

   logic [DIVIDEND_W-1:0] quo;
   logic [DIVISOR_W-1:0]  rem;
   logic [DIVISOR_W-1:0]  dvs;
   logic [CNT_W-1:0]      stepsLeft;
   logic [DIVISOR_W:0]    shifted;
   logic                  fits;
   logic [DIVISOR_W-1:0]  remNext;

   // Remainder stays below the divisor, so the trial difference always fits DIVISOR_W bits.
   always_comb begin
      shifted = {rem, quo[DIVIDEND_W-1]};
      fits    = (shifted >= {1'b0, dvs});
      remNext = fits ? (shifted[DIVISOR_W-1:0] - dvs) : shifted[DIVISOR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo           <= '0;
         rem           <= '0;
         dvs           <= '0;
         stepsLeft     <= '0;
         quotientValid <= 1'b0;
      end else if (load) begin
         quo           <= dividend;
         rem           <= '0;
         dvs           <= divisor;
         stepsLeft     <= CNT_W'(DIVIDEND_W);
         quotientValid <= 1'b0;
      end else if (stepsLeft != '0) begin
         quo           <= {quo[DIVIDEND_W-2:0], fits};
         rem           <= remNext;
         stepsLeft     <= stepsLeft - CNT_W'(1);
         quotientValid <= (stepsLeft == CNT_W'(1));
      end else begin
         quotientValid <= 1'b0;
      end
   end

   assign quotient = quo[QUOTIENT_W-1:0];

endmodule

// File: rtl/projection_bbox_finder.sv
// rtl/projection_bbox_finder.sv - per-axis bounding box and weighted centroid of streamed projection histograms
// Centroid divider and weighted sums are built only when CENTROID_EN is defined.
module projection_bbox_finder
   import projection_bbox_finder_pkg::*;
#(
   parameter int NUM_BINS  = NUM_BINS_DEFAULT,
   parameter int COUNT_W   = COUNT_W_DEFAULT,
   parameter int SUM_W     = SUM_W_DEFAULT,
   localparam int IDX_W    = $clog2(NUM_BINS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [COUNT_W-1:0]     binThreshold,
   projection_bbox_finder_if.slave hist,
   output logic [IDX_W-1:0]       xMin,
   output logic [IDX_W-1:0]       xMax,
   output logic [IDX_W-1:0]       yMin,
   output logic [IDX_W-1:0]       yMax,
   output logic [IDX_W-1:0]       xCentroid,
   output logic [IDX_W-1:0]       yCentroid,
   output logic                   objectFound,
   output logic                   busy,
   output logic                   done
);

   if (SUM_W < IDX_W + COUNT_W + IDX_W) begin : gSumWidthCheck
      $error("SUM_W too narrow for NUM_BINS and COUNT_W");
   end

   bboxState_t state, nextState;

   // Index 0 is the x axis, index 1 the y axis.
   logic [COUNT_W-1:0] binCount [2];
   logic               binValid [2];
   logic [IDX_W-1:0]   binIdx   [2];
   logic               accept   [2];
   logic               qualify  [2];
   logic [IDX_W:0]     beatCnt  [2];
   logic [IDX_W-1:0]   minIdx   [2];
   logic [IDX_W-1:0]   maxIdx   [2];
   logic               anyHit   [2];
   logic               allBeats;
   logic               objHit;

`ifdef CENTROID_EN
   localparam int TOT_W = COUNT_W + IDX_W;

   logic [TOT_W-1:0] total [2];
   logic [SUM_W-1:0] wSum  [2];
   logic             divLoad;
   logic             divValid;
   logic [IDX_W-1:0] divQuotient;
   logic [IDX_W-1:0] xCentQ;
`endif

   always_comb begin
      binCount[0] = hist.xHistIn;
      binCount[1] = hist.yHistIn;
      binValid[0] = hist.xValid;
      binValid[1] = hist.yValid;
      for (int a = 0; a < 2; a++) begin
         binIdx[a]  = beatCnt[a][IDX_W-1:0];
         // The counter's top bit marks a full axis; later beats are dropped.
         accept[a]  = (state == COLLECT) && binValid[a] && !beatCnt[a][IDX_W];
         qualify[a] = accept[a] && (binCount[a] > binThreshold);
      end
   end

   assign allBeats = beatCnt[0][IDX_W] & beatCnt[1][IDX_W];
   assign objHit   = anyHit[0] & anyHit[1];

   always_ff @(posedge clk) begin
      if (reset || state == REQ) begin
         for (int a = 0; a < 2; a++) begin
            beatCnt[a] <= '0;
            minIdx[a]  <= '0;
            maxIdx[a]  <= '0;
            anyHit[a]  <= 1'b0;
`ifdef CENTROID_EN
            total[a]   <= '0;
            wSum[a]    <= '0;
`endif
         end
      end else begin
         for (int a = 0; a < 2; a++) begin
            if (accept[a]) begin
               beatCnt[a] <= beatCnt[a] + (IDX_W + 1)'(1);
            end
            if (qualify[a]) begin
               if (!anyHit[a]) begin
                  minIdx[a] <= binIdx[a];
               end
               maxIdx[a] <= binIdx[a];
               anyHit[a] <= 1'b1;
`ifdef CENTROID_EN
               total[a]  <= total[a] + TOT_W'(binCount[a]);
               wSum[a]   <= wSum[a] + SUM_W'(binIdx[a]) * SUM_W'(binCount[a]);
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Divider runs are only worth doing when both axes hold an object.
   always_comb begin
      nextState = state;
`ifdef CENTROID_EN
      divLoad   = 1'b0;
`endif
      case (state)
         IDLE:    if (start) nextState = REQ;
         REQ:     nextState = COLLECT;
         COLLECT: begin
            if (allBeats) begin
               nextState = DIV_X;
`ifdef CENTROID_EN
               divLoad   = objHit;
`endif
            end
         end
         DIV_X: begin
`ifdef CENTROID_EN
            if (!objHit) begin
               nextState = DIV_Y;
            end else if (divValid) begin
               nextState = DIV_Y;
               divLoad   = 1'b1;
            end
`else
            nextState = DIV_Y;
`endif
         end
         DIV_Y: begin
`ifdef CENTROID_EN
            if (!objHit || divValid) nextState = FINISH;
`else
            nextState = FINISH;
`endif
         end
         FINISH:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign hist.readHistogram = (state == REQ);
   assign busy               = (state != IDLE);
   assign done               = (state == FINISH);

`ifdef CENTROID_EN
   projection_bbox_finder_seq_divider #(
      .DIVIDEND_W (SUM_W),
      .DIVISOR_W  (TOT_W),
      .QUOTIENT_W (IDX_W)
   ) u_divider (
      .clk           (clk),
      .reset         (reset),
      .load          (divLoad),
      .dividend      ((state == COLLECT) ? wSum[0] : wSum[1]),
      .divisor       ((state == COLLECT) ? total[0] : total[1]),
      .quotient      (divQuotient),
      .quotientValid (divValid)
   );
`else
   assign xCentroid = '0;
   assign yCentroid = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         xMin        <= '0;
         xMax        <= '0;
         yMin        <= '0;
         yMax        <= '0;
         objectFound <= 1'b0;
`ifdef CENTROID_EN
         xCentQ      <= '0;
         xCentroid   <= '0;
         yCentroid   <= '0;
`endif
      end else begin
`ifdef CENTROID_EN
         if (state == DIV_X && divValid) begin
            xCentQ <= divQuotient;
         end
`endif
         if (state == FINISH) begin
            objectFound <= objHit;
            xMin        <= objHit ? minIdx[0] : '0;
            xMax        <= objHit ? maxIdx[0] : '0;
            yMin        <= objHit ? minIdx[1] : '0;
            yMax        <= objHit ? maxIdx[1] : '0;
`ifdef CENTROID_EN
            // The y run's quotient is still held by the divider in FINISH.
            xCentroid   <= objHit ? xCentQ : '0;
            yCentroid   <= objHit ? divQuotient : '0;
`endif
         end
      end
   end

endmodule

// File: doc/projection_bbox_finder.md
Name: projection_bbox_finder

Overview:
Consumes the x/y projection histograms streamed out of the histogram stage after median filtering. Finds the object's bounding box: first and last bin whose count exceeds a programmable threshold, per axis. Computes the count-weighted centroid per axis with a shared sequential divider. Sits directly downstream of the histogram stage, whose `readHistogram` it drives, and feeds the host/readout logic.

Parameters:
- NUM_BINS, 256, bins per axis; power of two; IDX_W = log2(NUM_BINS).
- COUNT_W, 8, width of one histogram bin count.
- SUM_W, 24, weighted-sum width; must be >= IDX_W + COUNT_W + IDX_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin a new search
- binThreshold  in  COUNT_W  bin qualifies if count > binThreshold
- readHistogram  out  1  one-cycle request to histogram stage
- xHistIn  in  COUNT_W  x bin count, valid when xValid
- xValid  in  1  x beat strobe; bins arrive in index order 0..NUM_BINS-1
- yHistIn  in  COUNT_W  y bin count, valid when yValid
- yValid  in  1  y beat strobe; same ordering
- xMin, xMax, yMin, yMax  out  IDX_W each  bounding box
- xCentroid, yCentroid  out  IDX_W each  truncated weighted mean index
- objectFound  out  1  both axes had >= 1 qualifying bin
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when results are valid

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters/accumulators 0. Reset mid-operation aborts immediately; no done pulse.
- FSM states: IDLE, REQ, COLLECT, DIV_X, DIV_Y, FINISH.
  - IDLE -> REQ on start.
  - REQ: readHistogram=1 for exactly one cycle; clears accumulators; -> COLLECT.
  - COLLECT -> DIV_X when both axes have accepted NUM_BINS beats.
  - DIV_X -> DIV_Y -> FINISH, one divider run each.
  - FINISH: done=1 for one cycle; -> IDLE.
- start while busy is ignored.
- Per axis, independently, in COLLECT:
  - A 9-bit beat counter gives the bin index. Beats beyond NUM_BINS are ignored.
  - x and y beats may coincide, interleave, or arrive in any relative order.
  - Qualifying bin (count > binThreshold): min = index of first qualifying bin; max = index of last.
  - Each qualifying bin adds count to the total (COUNT_W+IDX_W bits) and index*count to the weighted sum (SUM_W bits).
  - Non-qualifying bins do not contribute.
- Divider (shared): unsigned restoring, quotient = weighted sum / total, truncated. Latency IDX_W+COUNT_W+IDX_W+1 = 25 cycles from load to quotient valid. The quotient always fits IDX_W, since it is a weighted average of indices.
- Empty axis (total == 0): objectFound=0; all min/max/centroid outputs = 0; both divider runs skipped (DIV_X/DIV_Y take 1 cycle each).
- Outputs update only in FINISH and hold until the next FINISH or reset.
- Latency: done is asserted 52 cycles after the cycle of the last accepted beat when an object is present; 4 cycles when empty.
- A single qualifying bin at index i gives min = max = centroid = i.

Optional Feature:
- CENTROID_EN
  - Defined: divider instantiated; centroid computed as above.
  - Undefined: no divider or weighted-sum accumulators; xCentroid/yCentroid tied to 0; DIV_X/DIV_Y take 1 cycle each, so done always follows the last beat by 4 cycles.
  - Bounding box behaviour is identical in both builds.

Decomposition:
- Shared package: FSM state encoding; NUM_BINS/COUNT_W/SUM_W defaults; derived IDX_W and divider latency constant.
- One natural sub-module: seq_divider (parameterised dividend/divisor width; load/start in, quotient + valid pulse out). Used only under CENTROID_EN.

Test Plan:
- Threshold 10; x bins 40..60 = 20, y bins 100..110 = 50, rest 0 -> xMin=40, xMax=60, xCentroid=50, yMin=100, yMax=110, yCentroid=105, objectFound=1, done 52 cycles after last beat.
- All bins 5, threshold 5 (count equals threshold) -> objectFound=0, all outputs 0, done 4 cycles after last beat.
- Single qualifying bin x[255]=255, y[0]=255 -> xMin=xMax=xCentroid=255, yMin=yMax=yCentroid=0 (exercises max-width sums).
- y stream delayed 300 cycles after x, plus 10 extra x beats -> extra beats ignored; results match the aligned run.
- Assert reset mid-COLLECT, then start -> no done for the aborted run; outputs 0; second run correct; readHistogram pulses once per accepted start.
- start pulsed during DIV_X -> ignored; one done only. CENTROID_EN undefined -> centroids 0, box unchanged.
